addsub_pipe: RTL and testbench

- Parametrised, pipelined unsigned adder/subtractor with a carry/borrow flag and a running accumulator.
- Successor to the team's 4-bit combinational add/sub block. Adds WIDTH generalisation, a valid/ready stream interface, a 2-stage pipeline and accumulate modes.
- Sits between operand producers and the datapath result bus.

---
 rtl/addsub_pkg.sv | 30 +++
 rtl/addsub_core.sv | 53 +++++
 rtl/addsub_pipe.sv | 165 ++++++++++++++++
 tb/tb_addsub_pipe.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// ---------------------------------------------------------------------------
// addsub_pkg
//   Shared definitions for the addsub_pipe adder/subtractor.
//   - op_t          : 2-bit operation code carried with each operand beat
//   - OP_*          : operation encodings (ADD, SUB, ACC_ADD, ACC_SUB)
//   - op_dec_t      : decoded view of an op (accumulate? subtract?)
//   - op_decode()   : op_t -> op_dec_t
// ---------------------------------------------------------------------------
package addsub_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_ADD     = 2'b00;
    localparam op_t OP_SUB     = 2'b01;
    localparam op_t OP_ACC_ADD = 2'b10;
    localparam op_t OP_ACC_SUB = 2'b11;

    typedef struct packed {
        logic is_acc;
        logic is_sub;
    } op_dec_t;

    function automatic op_dec_t op_decode(input op_t op);
        op_dec_t dec;
        dec.is_acc = (op == OP_ACC_ADD) || (op == OP_ACC_SUB);
        dec.is_sub = (op == OP_SUB)     || (op == OP_ACC_SUB);
        return dec;
    endfunction

endpackage

// File: rtl/addsub_core.sv
// ---------------------------------------------------------------------------
// addsub_core
//   Purely combinational WIDTH-bit unsigned add/subtract with carry/borrow.
//   The operation is evaluated at WIDTH+1 bits; the extra MSB is the carry
//   for an add and the borrow (a < b) for a subtract.
//
//   Optional build macro: ADDSUB_PIPE_SATURATE_EN
//     defined   -> on flag=1 the result clamps (add: all-ones, sub: zero)
//     undefined -> modulo 2^WIDTH wrap, no clamp logic
//
//   Ports
//     a_i      in  WIDTH  operand A (minuend for subtract)
//     b_i      in  WIDTH  operand B (subtrahend for subtract)
//     sub_i    in  1      1 = subtract, 0 = add
//     result_o out WIDTH  result
//     flag_o   out 1      carry out (add) / borrow (subtract)
// ---------------------------------------------------------------------------
module addsub_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] result_o,
    output logic             flag_o
);

    logic [WIDTH:0] ext;

    // With a zero-extended subtract, the MSB of the WIDTH+1 difference is
    // set exactly when a < b, so carry and borrow share one bit position.
    always_comb begin
        if (sub_i) begin
            ext = {1'b0, a_i} - {1'b0, b_i};
        end else begin
            ext = {1'b0, a_i} + {1'b0, b_i};
        end
    end

    assign flag_o = ext[WIDTH];

`ifdef ADDSUB_PIPE_SATURATE_EN
    always_comb begin
        result_o = ext[WIDTH-1:0];
        if (ext[WIDTH]) begin
            result_o = sub_i ? '0 : '1;
        end
    end
`else
    assign result_o = ext[WIDTH-1:0];
`endif

endmodule

// File: rtl/addsub_pipe.sv
// ---------------------------------------------------------------------------
// addsub_pipe
//   Two-stage pipelined unsigned adder/subtractor with a running accumulator
//   and valid/ready streaming on both sides.
//     S1 : operand register (in_a, in_b, in_op)
//     S2 : output register; arithmetic happens on the S1 -> S2 transfer
//   The accumulator lives in S2 so back-to-back ACC ops chain without a
//   bubble. Latency is two edges from acceptance to out_valid.
//
//   Optional build macro: ADDSUB_PIPE_SATURATE_EN (clamp on carry/borrow,
//   see addsub_core). The clamped value is what the accumulator stores.
//
//   Parameters
//     WIDTH     operand/result width (>= 2)
//     ACC_INIT  accumulator value after reset or acc_clr
//
//   Ports
//     clk        in  1      clock, rising edge
//     rst_n      in  1      asynchronous active-low reset
//     in_valid   in  1      operand beat valid
//     in_ready   out 1      operand beat can be accepted
//     in_a       in  WIDTH  operand A (ignored by ACC ops)
//     in_b       in  WIDTH  operand B
//     in_op      in  2      00 ADD, 01 SUB, 10 ACC_ADD, 11 ACC_SUB
//     acc_clr    in  1      synchronous accumulator clear pulse
//     out_valid  out 1      result beat valid
//     out_ready  in  1      consumer accepts result
//     out_result out WIDTH  result
//     out_flag   out 1      carry (add) / borrow (subtract)
//     acc_value  out WIDTH  accumulator contents
// ---------------------------------------------------------------------------
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_flag,
    output logic [WIDTH-1:0] acc_value
);

    // Stage 1
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    op_t              s1_op_q, s1_op_d;

    // Stage 2 / output register and accumulator
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_q, flag_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    // Handshake and datapath
    logic             s2_can_load;
    logic             s2_load;
    logic             in_fire;
    op_dec_t          s1_dec;
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_result;
    logic             core_flag;

    assign s2_can_load = !out_valid_q || out_ready;
    assign s2_load     = s1_valid_q && s2_can_load;
    assign in_ready    = !s1_valid_q || s2_can_load;
    assign in_fire     = in_valid && in_ready;
    assign s1_dec      = op_decode(s1_op_q);

    // An ACC op loading in the same cycle as acc_clr sees the cleared value,
    // giving clear-then-accumulate semantics.
    always_comb begin
        core_a = s1_a_q;
        if (s1_dec.is_acc) begin
            core_a = acc_clr ? ACC_INIT : acc_q;
        end
    end

    addsub_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i      (core_a),
        .b_i      (s1_b_q),
        .sub_i    (s1_dec.is_sub),
        .result_o (core_result),
        .flag_o   (core_flag)
    );

    always_comb begin
        s1_a_d  = s1_a_q;
        s1_b_d  = s1_b_q;
        s1_op_d = s1_op_q;
        if (in_fire) begin
            s1_a_d  = in_a;
            s1_b_d  = in_b;
            s1_op_d = in_op;
        end
        // S1 empties when its beat moves to S2, unless refilled this edge.
        if (in_fire) begin
            s1_valid_d = 1'b1;
        end else if (s2_can_load) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flag_d      = flag_q;
        acc_d       = acc_q;
        if (s2_can_load) begin
            out_valid_d = s1_valid_q;
        end
        if (s2_load) begin
            result_d = core_result;
            flag_d   = core_flag;
        end
        if (acc_clr) begin
            acc_d = ACC_INIT;
        end
        if (s2_load && s1_dec.is_acc) begin
            acc_d = core_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= OP_ADD;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flag_q      <= 1'b0;
            acc_q       <= ACC_INIT;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flag_q      <= flag_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = result_q;
    assign out_flag   = flag_q;
    assign acc_value  = acc_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_addsub_pipe
//   Directed bench for addsub_pipe. Two instances share one clock:
//   u4 (WIDTH=4) for arithmetic/backpressure, u8 (WIDTH=8, ACC_INIT=0) for
//   the accumulator, wrap-around and reset-in-flight cases.
// ---------------------------------------------------------------------------
module tb_addsub_pipe;
    import addsub_pkg::*;

`ifdef ADDSUB_PIPE_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // WIDTH=4 instance
    logic       v4 = 1'b0, r4, clr4 = 1'b0, ov4, ordy4 = 1'b1, flag4;
    logic [3:0] a4 = '0, b4 = '0, res4, acc4;
    logic [1:0] op4 = OP_ADD;

    // WIDTH=8 instance
    logic       v8 = 1'b0, r8, clr8 = 1'b0, ov8, ordy8 = 1'b1, flag8;
    logic [7:0] a8 = '0, b8 = '0, res8, acc8;
    logic [1:0] op8 = OP_ADD;

    addsub_pipe #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4),
        .in_a(a4), .in_b(b4), .in_op(op4), .acc_clr(clr4),
        .out_valid(ov4), .out_ready(ordy4), .out_result(res4),
        .out_flag(flag4), .acc_value(acc4)
    );

    addsub_pipe #(.WIDTH(8), .ACC_INIT(8'd0)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8),
        .in_a(a8), .in_b(b8), .in_op(op8), .acc_clr(clr8),
        .out_valid(ov8), .out_ready(ordy8), .out_result(res8),
        .out_flag(flag8), .acc_value(acc8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv4(input logic v, input op_t op, input logic [3:0] a, input logic [3:0] b);
        v4 = v; op4 = op; a4 = a; b4 = b;
    endtask

    task automatic drv8(input logic v, input op_t op, input logic [7:0] a, input logic [7:0] b);
        v8 = v; op8 = op; a8 = a; b8 = b;
    endtask

    // Backpressure stream: operands and expected sums
    logic [3:0] bp_a   [4] = '{4'd1, 4'd2, 4'd4, 4'd7};
    logic [3:0] bp_b   [4] = '{4'd1, 4'd3, 4'd4, 4'd7};
    logic [3:0] bp_exp [4] = '{4'd2, 4'd5, 4'd8, 4'd14};

    initial begin
        int  si;
        int  ri;
        bit  fire;
        bit  seen;

        // ---------------- reset ----------------
        #2 rst_n = 1'b0;
        #2;
        chk("rst_out_valid4", ov4, 0);
        chk("rst_result4",    res4, 0);
        chk("rst_flag4",      flag4, 0);
        chk("rst_acc8",       acc8, 0);
        chk("rst_out_valid8", ov8, 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready4", r4, 1);

        // ---------------- ADD 9+8, WIDTH=4 ----------------
        drv4(1'b1, OP_ADD, 4'd9, 4'd8);
        step();
        drv4(1'b0, OP_ADD, 4'd0, 4'd0);
        chk("add_lat_not_yet", ov4, 0);
        step();
        chk("add_valid",  ov4, 1);
        chk("add_result", res4, SAT ? 15 : 1);
        chk("add_flag",   flag4, 1);

        // ---------------- SUB 3-5 then 5-3 ----------------
        drv4(1'b1, OP_SUB, 4'd3, 4'd5);
        step();
        drv4(1'b1, OP_SUB, 4'd5, 4'd3);
        step();
        chk("sub35_result", res4, SAT ? 0 : 14);
        chk("sub35_flag",   flag4, 1);
        drv4(1'b0, OP_ADD, 4'd0, 4'd0);
        step();
        chk("sub53_valid",  ov4, 1);
        chk("sub53_result", res4, 2);
        chk("sub53_flag",   flag4, 0);
        step();
        chk("sub_drained", ov4, 0);

        // ---------------- saturation vectors ----------------
        drv4(1'b1, OP_ADD, 4'd12, 4'd9);
        step();
        drv4(1'b1, OP_SUB, 4'd2, 4'd7);
        step();
        chk("add12_9_result", res4, SAT ? 15 : 5);
        chk("add12_9_flag",   flag4, 1);
        drv4(1'b0, OP_ADD, 4'd0, 4'd0);
        step();
        chk("sub2_7_result", res4, SAT ? 0 : 11);
        chk("sub2_7_flag",   flag4, 1);
        step();

        // ---------------- backpressure ----------------
        ordy4 = 1'b0;
        drv4(1'b1, OP_ADD, bp_a[0], bp_b[0]);
        step();
        drv4(1'b1, OP_ADD, bp_a[1], bp_b[1]);
        step();
        drv4(1'b1, OP_ADD, bp_a[2], bp_b[2]);
        #1;
        chk("bp_in_ready_low", r4, 0);
        chk("bp_valid",        ov4, 1);
        chk("bp_hold0",        res4, 2);
        step();
        chk("bp_hold1",          res4, 2);
        chk("bp_in_ready_low1",  r4, 0);
        step();
        chk("bp_hold2",      res4, 2);
        chk("bp_hold2_flag", flag4, 0);
        chk("bp_hold2_vld",  ov4, 1);
        ordy4 = 1'b1;
        #1;
        chk("bp_in_ready_back", r4, 1);
        si = 2;
        ri = 0;
        for (int c = 0; c < 20 && ri < 4; c++) begin
            if (ov4 && ordy4) begin
                chk("bp_order", res4, bp_exp[ri]);
                ri++;
            end
            fire = v4 && r4;
            step();
            if (fire) begin
                si++;
                if (si < 4) drv4(1'b1, OP_ADD, bp_a[si], bp_b[si]);
                else        drv4(1'b0, OP_ADD, 4'd0, 4'd0);
            end
            #1;
        end
        chk("bp_count", ri, 4);
        chk("bp_no_dup", ov4, 0);

        // ---------------- accumulator chain, WIDTH=8 ----------------
        drv8(1'b1, OP_ACC_ADD, 8'd99, 8'd5);
        step();
        drv8(1'b1, OP_ACC_ADD, 8'd99, 8'd7);
        step();
        chk("acc1_result", res8, 5);
        chk("acc1_acc",    acc8, 5);
        drv8(1'b1, OP_ACC_SUB, 8'd99, 8'd2);
        step();
        chk("acc2_result", res8, 12);
        chk("acc2_acc",    acc8, 12);
        drv8(1'b0, OP_ADD, 8'd0, 8'd0);
        step();
        chk("acc3_result", res8, 10);
        chk("acc3_flag",   flag8, 0);
        chk("acc3_acc",    acc8, 10);

        // acc_clr in the same cycle the ACC op loads S2
        drv8(1'b1, OP_ACC_ADD, 8'd99, 8'd3);
        step();
        drv8(1'b0, OP_ADD, 8'd0, 8'd0);
        clr8 = 1'b1;
        step();
        clr8 = 1'b0;
        chk("clr_valid",  ov8, 1);
        chk("clr_result", res8, 3);
        chk("clr_acc",    acc8, 3);

        // ---------------- wrap-around, plain ops leave acc alone ----------------
        drv8(1'b1, OP_ADD, 8'd255, 8'd1);
        step();
        drv8(1'b1, OP_SUB, 8'd0, 8'd1);
        step();
        chk("wrap_add_result", res8, SAT ? 255 : 0);
        chk("wrap_add_flag",   flag8, 1);
        chk("wrap_add_acc",    acc8, 3);
        drv8(1'b0, OP_ADD, 8'd0, 8'd0);
        step();
        chk("wrap_sub_result", res8, SAT ? 0 : 255);
        chk("wrap_sub_flag",   flag8, 1);
        chk("wrap_sub_acc",    acc8, 3);
        step();

        // ---------------- reset with beats in flight ----------------
        drv8(1'b1, OP_ADD, 8'd1, 8'd2);
        step();
        drv8(1'b1, OP_ACC_ADD, 8'd0, 8'd4);
        step();
        drv8(1'b0, OP_ADD, 8'd0, 8'd0);
        chk("pre_rst_valid", ov8, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid",  ov8, 0);
        chk("async_rst_acc",    acc8, 0);
        chk("async_rst_result", res8, 0);
        step();
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (ov8) seen = 1'b1;
        end
        chk("no_stale_beat", seen, 0);
        chk("post_rst_acc",  acc8, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
